// File: rtl/cam_pixel_tx.sv
// cam_pixel_tx: camera pixel-bus transmitter (VSYNC/HREF/8-bit DATA, RGB565 high byte first)
module cam_pixel_tx #(
  parameter int WIDTH   = 176,
  parameter int HEIGHT  = 144,
  parameter int VS_CYC  = 16,
  parameter int VBP_CYC = 32,
  parameter int HB_CYC  = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EN,
  input  logic        MODE,
  input  logic [15:0] PIX_IN,
  output logic        PIX_REQ,
  output logic [7:0]  PIX_X,
  output logic [7:0]  PIX_Y,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  DATA,
  output logic        FRAME_DONE,
  output logic        BUSY
);
  localparam int LB = 2 * WIDTH;
  localparam int M1 = VS_CYC > VBP_CYC ? VS_CYC : VBP_CYC;
  localparam int M2 = LB > HB_CYC ? LB : HB_CYC;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  localparam logic [CW-1:0] VS_L  = CW'(VS_CYC - 1);
  localparam logic [CW-1:0] VBP_L = CW'(VBP_CYC - 1);
  localparam logic [CW-1:0] LB_L  = CW'(LB - 1);
  localparam logic [CW-1:0] HB_L  = CW'(HB_CYC - 1);
  localparam logic [7:0]    ROW_L = 8'(HEIGHT - 1);
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  typedef enum logic [2:0] {S_IDLE, S_VS, S_VBP, S_LINE, S_HBL} state_t;
  state_t st, ns;
  logic [CW-1:0] cnt, nc;
  logic [7:0] row, nrow, lo_r, x_n, y_n;
  logic mode_r, req_n;
  logic [2:0] bar_i;
  logic [15:0] src;
  assign bar_i = 3'((16'(PIX_X) * 16'd8) / 16'(WIDTH));
  assign src = mode_r ? BARS[bar_i] : PIX_IN;
  always_comb begin
    ns = st;
    nc = cnt + 1'b1;
    nrow = row;
    case (st)
      S_IDLE: begin
        nc = '0;
        if (EN) ns = S_VS;
      end
      S_VS: if (cnt == VS_L) begin
        ns = S_VBP;
        nc = '0;
      end
      S_VBP: if (cnt == VBP_L) begin
        ns = S_LINE;
        nc = '0;
      end
      S_LINE: if (cnt == LB_L) begin
        ns = S_HBL;
        nc = '0;
      end
      S_HBL: if (cnt == HB_L) begin
        nc = '0;
        if (row == ROW_L) begin
          nrow = '0;
          ns = EN ? S_VS : S_IDLE;
        end else begin
          nrow = row + 8'd1;
          ns = S_LINE;
        end
      end
      default: begin
        ns = S_IDLE;
        nc = '0;
      end
    endcase
  end
  // A request precedes every high-byte cycle, so the source has one clock to answer
  assign req_n = (ns == S_VBP && nc == VBP_L) || (ns == S_HBL && nc == HB_L && row != ROW_L) ||
                 (ns == S_LINE && nc[0] && nc != LB_L);
  assign x_n = ns == S_LINE ? 8'(nc[CW-1:1]) + 8'd1 : 8'd0;
  assign y_n = ns == S_HBL ? nrow + 8'd1 : nrow;
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      st <= S_IDLE;
      cnt <= '0;
      row <= '0;
      lo_r <= '0;
      mode_r <= 1'b0;
      PIX_REQ <= 1'b0;
      PIX_X <= '0;
      PIX_Y <= '0;
      VSYNC <= 1'b0;
      HREF <= 1'b0;
      DATA <= '0;
      FRAME_DONE <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      st <= ns;
      cnt <= nc;
      row <= nrow;
      if (ns == S_VS && st != S_VS) mode_r <= MODE;
      VSYNC <= ns == S_VS;
      HREF <= ns == S_LINE;
      BUSY <= ns != S_IDLE;
      FRAME_DONE <= ns == S_HBL && nc == HB_L && row == ROW_L;
      PIX_REQ <= req_n;
      if (req_n) begin
        PIX_X <= x_n;
        PIX_Y <= y_n;
      end else if (ns == S_IDLE) begin
        PIX_X <= '0;
        PIX_Y <= '0;
      end
      DATA <= ns != S_LINE ? 8'd0 : nc[0] ? lo_r : src[15:8];
      if (ns == S_LINE && !nc[0]) lo_r <= src[7:0];
    end
  end
endmodule

// File: tb/tb_cam_pixel_tx.sv
// tb_cam_pixel_tx: randomized frame-level check of cam_pixel_tx against a cycle-list reference model
module tb_cam_pixel_tx;
  localparam int SW = 4, SH = 2, SVS = 2, SVBP = 3, SHB = 2;
  localparam int DW = 176, DH = 144, DVS = 16, DVBP = 32, DHB = 8;
  typedef struct packed {
    logic vs, href, fd, busy, req, last;
    logic [7:0] data, x, y;
  } rec_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, big = 1'b0;
  logic [15:0] salt = 16'h0, junk = 16'h0, pin_s, pin_d;
  logic req_s, vs_s, href_s, fd_s, busy_s, req_d, vs_d, href_d, fd_d, busy_d;
  logic [7:0] x_s, y_s, data_s, x_d, y_d, data_d;
  logic [12:0] o_main;
  logic [15:0] o_xy;
  int total = 0, bad = 0;
  rec_t q[$];
  always #5 clk = ~clk;
  always @(negedge clk) junk <= 16'($urandom);
  assign pin_s = req_s ? ({y_s, x_s} ^ salt) : junk;
  assign pin_d = req_d ? ({y_d, x_d} ^ salt) : junk;
  assign o_main = big ? {vs_d, href_d, fd_d, busy_d, req_d, data_d} : {vs_s, href_s, fd_s, busy_s, req_s, data_s};
  assign o_xy = big ? {x_d, y_d} : {x_s, y_s};
  cam_pixel_tx #(.WIDTH(SW), .HEIGHT(SH), .VS_CYC(SVS), .VBP_CYC(SVBP), .HB_CYC(SHB)) dut_s (
    .CLK(clk), .RESET_N(rst_n), .EN(en), .MODE(mode), .PIX_IN(pin_s), .PIX_REQ(req_s),
    .PIX_X(x_s), .PIX_Y(y_s), .VSYNC(vs_s), .HREF(href_s), .DATA(data_s),
    .FRAME_DONE(fd_s), .BUSY(busy_s));
  cam_pixel_tx dut_d (
    .CLK(clk), .RESET_N(rst_n), .EN(en), .MODE(mode), .PIX_IN(pin_d), .PIX_REQ(req_d),
    .PIX_X(x_d), .PIX_Y(y_d), .VSYNC(vs_d), .HREF(href_d), .DATA(data_d),
    .FRAME_DONE(fd_d), .BUSY(busy_d));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] bar(input int x, input int w);
    case ((x * 8) / w)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction
  task automatic push_frame(input bit m, input int w, h, vs, vbp, hb);
    rec_t r, p;
    logic [15:0] pix;
    r = '0;
    r.busy = 1'b1;
    r.vs = 1'b1;
    repeat (vs) q.push_back(r);
    r.vs = 1'b0;
    repeat (vbp) q.push_back(r);
    for (int y = 0; y < h; y++) begin
      for (int b = 0; b < 2 * w; b++) begin
        pix = m ? bar(b / 2, w) : ({8'(y), 8'(b / 2)} ^ salt);
        if (b % 2 == 0) begin
          p = q.pop_back();
          p.req = 1'b1;
          p.x = 8'(b / 2);
          p.y = 8'(y);
          q.push_back(p);
        end
        r = '0;
        r.busy = 1'b1;
        r.href = 1'b1;
        r.data = (b % 2 == 1) ? pix[7:0] : pix[15:8];
        q.push_back(r);
      end
      for (int i = 0; i < hb; i++) begin
        r = '0;
        r.busy = 1'b1;
        r.fd = (y == h - 1 && i == hb - 1);
        r.last = r.fd;
        q.push_back(r);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_frames(input int nfr, input logic [3:0] modes, input int cut);
    int f;
    q.delete();
    for (int i = 0; i < nfr; i++)
      if (big) push_frame(modes[i], DW, DH, DVS, DVBP, DHB);
      else push_frame(modes[i], SW, SH, SVS, SVBP, SHB);
    en = 1'b1;
    mode = modes[0];
    step();
    f = 0;
    for (int j = 0; j < q.size(); j++) begin
      check("frame", 32'(o_main), 32'({q[j].vs, q[j].href, q[j].fd, q[j].busy, q[j].req, q[j].data}));
      if (q[j].req) check("pix_xy", 32'(o_xy), 32'({q[j].x, q[j].y}));
      if (j == cut) begin
        rst_n = 1'b0;
        en = 1'($urandom);
        step();
        check("reset_mid", 32'({o_main, o_xy}), 32'd0);
        rst_n = 1'b1;
        en = 1'b0;
        return;
      end
      if (q[j].last) begin
        f++;
        en = f < nfr;
        mode = f < nfr ? modes[f] : 1'($urandom);
      end else begin
        en = 1'($urandom);
        mode = 1'($urandom);
      end
      step();
    end
    repeat (3) begin
      check("idle", 32'({o_main, o_xy}), 32'd0);
      step();
    end
  endtask
  initial begin
    salt = 16'($urandom);
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_s", 32'({o_main, o_xy}), 32'd0);
    big = 1'b1;
    check("reset_d", 32'({o_main, o_xy}), 32'd0);
    big = 1'b0;
    rst_n = 1'b1;
    step();
    run_frames(1, 4'b0000, -1);
    run_frames(3, 4'b0000, -1);
    run_frames(2, 4'b0010, -1);
    run_frames(1, 4'b0001, -1);
    run_frames(1, 4'b0000, SVS + SVBP + (2 * SW + SHB) + 5);
    run_frames(1, 4'b0000, -1);
    repeat (6) begin
      int n, c;
      n = $urandom_range(1, 3);
      c = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 60) : -1;
      run_frames(n, 4'($urandom), c);
    end
    rst_n = 1'b0;
    step();
    big = 1'b1;
    check("reset_d2", 32'({o_main, o_xy}), 32'd0);
    rst_n = 1'b1;
    step();
    run_frames(1, 4'b0001, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
